shift_arbiter: RTL and testbench

Shares the single 16-bit barrel shifter (`Shifter`) between two independent requesters, e.g. the execute-stage ALU path and the load/store alignment path. Arbitration is round-robin with valid/ready handshakes on both requester ports. A one-entry registered result buffer gives fixed 1-cycle latency and full throughput under no backpressure. Results return on one response port tagged with source and requester tag.

---
 rtl/shift_pkg.sv | 13 +
 rtl/Shifter.sv | 26 ++
 rtl/shift_arbiter.sv | 101 ++++++++++
 tb/tb_shift_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared constants for the shift arbiter slice.
//   MODE_*   : shifter operation encodings carried on reqN_mode.
//   ST_*     : result buffer state encoding (EMPTY / FULL).
package shift_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/Shifter.sv
// Shifter: combinational 16-bit barrel shifter.
//   data_in  : operand
//   shamt    : shift amount 0-15
//   mode     : 00 SLL, 01 SRA, 10 ROR (11 also executes as ROR)
//   data_out : result
module Shifter
    import shift_pkg::*;
(
    input  logic [15:0] data_in,
    input  logic [3:0]  shamt,
    input  logic [1:0]  mode,
    output logic [15:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (mode)
            MODE_SLL: data_out = data_in << shamt;
            MODE_SRA: data_out = $signed(data_in) >>> shamt;
            // Rotate: a left shift by 16 yields zero, so shamt 0 passes through.
            default:  data_out = (data_in >> shamt) |
                                 (data_in << (5'd16 - {1'b0, shamt}));
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one barrel shifter between two
// requesters, with a one-entry registered result buffer (1-cycle latency).
//   clk, rst                : clock, synchronous active-high reset
//   req0_* / req1_*         : valid/ready request ports (data, shamt, mode, tag)
//   rsp_valid / rsp_ready   : response handshake
//   rsp_data/rsp_src/rsp_tag: shifted result, source index, request tag
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [3:0]       req0_shamt,
    input  logic [1:0]       req0_mode,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [3:0]       req1_shamt,
    input  logic [1:0]       req1_mode,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag
);

    logic [0:0]       state;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             can_accept;
    logic             accept;

    logic [WIDTH-1:0] sh_data;
    logic [3:0]       sh_shamt;
    logic [1:0]       sh_mode;
    logic [TAG_W-1:0] sel_tag;
    logic [WIDTH-1:0] sh_result;

    // On contention the requester not granted last wins.
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);

    assign can_accept = (state == ST_EMPTY) | rsp_ready;

    assign req0_ready = grant0 & can_accept & ~rst;
    assign req1_ready = grant1 & can_accept & ~rst;
    assign accept     = req0_ready | req1_ready;

    assign rsp_valid  = (state == ST_FULL);

    always_comb begin
        sh_data  = req0_data;
        sh_shamt = req0_shamt;
        sh_mode  = req0_mode;
        sel_tag  = req0_tag;
        if (grant1) begin
            sh_data  = req1_data;
            sh_shamt = req1_shamt;
            sh_mode  = req1_mode;
            sel_tag  = req1_tag;
        end
    end

    Shifter u_shifter (
        .data_in  (sh_data),
        .shamt    (sh_shamt),
        .mode     (sh_mode),
        .data_out (sh_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            last_grant <= 1'b1;
            rsp_data   <= '0;
            rsp_src    <= 1'b0;
            rsp_tag    <= '0;
        end else if (accept) begin
            // Covers both EMPTY fill and FULL drain-and-reload in one edge.
            state      <= ST_FULL;
            last_grant <= grant1;
            rsp_data   <= sh_result;
            rsp_src    <= grant1;
            rsp_tag    <= sel_tag;
        end else if (state == ST_FULL && rsp_ready) begin
            state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    localparam int WIDTH = 16;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [15:0]      req0_data = '0, req1_data = '0;
    logic [3:0]       req0_shamt = '0, req1_shamt = '0;
    logic [1:0]       req0_mode = '0, req1_mode = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [15:0]      rsp_data;
    logic             rsp_src;
    logic [TAG_W-1:0] rsp_tag;

    int errors = 0;
    int checks = 0;

    shift_arbiter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_mode(req0_mode), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_mode(req1_mode), .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_src(rsp_src), .rsp_tag(rsp_tag)
    );

    always #5 clk = ~clk;

    // Bit-level reference: result bit i is taken from the operand bit that
    // moves into position i under each operation.
    function automatic logic [15:0] ref_shift(input logic [15:0] d,
                                              input logic [3:0] s,
                                              input logic [1:0] m);
        logic [15:0] r;
        int si;
        si = int'(s);
        for (int i = 0; i < 16; i++) begin
            if (m == 2'b00)      r[i] = (i >= si) ? d[i - si] : 1'b0;
            else if (m == 2'b01) r[i] = (i + si < 16) ? d[i + si] : d[15];
            else                 r[i] = d[(i + si) % 16];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Presents one request on req0, returns whether it was ready before the
    // edge and what the response port shows right after it.
    task automatic send0(input logic [15:0] d, input logic [3:0] s,
                         input logic [1:0] m, input logic [TAG_W-1:0] t,
                         output logic rdy, output logic v,
                         output logic [15:0] od, output logic osrc,
                         output logic [TAG_W-1:0] otag);
        req0_valid = 1'b1; req0_data = d; req0_shamt = s; req0_mode = m; req0_tag = t;
        req1_valid = 1'b0;
        #1;
        rdy = req0_ready;
        tick();
        req0_valid = 1'b0;
        v = rsp_valid; od = rsp_data; osrc = rsp_src; otag = rsp_tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_src, rsp_tag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%b t=%h expected all zero",
                     rsp_valid, rsp_data, rsp_src, rsp_tag);
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [15:0] din [3] = '{16'h00FF, 16'h8000, 16'h1234};
        logic [3:0]  sin [3] = '{4'd4, 4'd3, 4'd8};
        logic [1:0]  min [3] = '{2'b00, 2'b01, 2'b10};
        logic [15:0] exp_d [3] = '{16'h0FF0, 16'hF000, 16'h3412};
        logic rdy, v, osrc;
        logic [15:0] od;
        logic [TAG_W-1:0] otag;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send0(din[i], sin[i], min[i], TAG_W'(i + 2), rdy, v, od, osrc, otag);
            checks++;
            if ({rdy, v, od, osrc, otag} !== {1'b1, 1'b1, exp_d[i], 1'b0, TAG_W'(i + 2)}) begin
                errors++;
                $display("FAIL single_%0d: got rdy=%b v=%b d=%h s=%b t=%0d expected rdy=1 v=1 d=%h s=0 t=%0d",
                         i, rdy, v, od, osrc, otag, exp_d[i], i + 2);
            end
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_contention();
        logic [15:0] d0, d1, exp_d;
        logic exp_src;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d0 = 16'(16'h0101 * (i + 1));
            d1 = 16'(16'h1010 * (i + 1));
            req0_valid = 1'b1; req0_data = d0; req0_shamt = 4'(i); req0_mode = 2'b00; req0_tag = TAG_W'(i);
            req1_valid = 1'b1; req1_data = d1; req1_shamt = 4'(i); req1_mode = 2'b10; req1_tag = TAG_W'(7 - i);
            exp_src = (i % 2) == 1;
            exp_d = exp_src ? ref_shift(d1, 4'(i), 2'b10) : ref_shift(d0, 4'(i), 2'b00);
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (exp_src ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL contention_grant_%0d: got r1r0=%b%b expected grant %0d",
                         i, req1_ready, req0_ready, exp_src);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_src, rsp_data, rsp_tag} !==
                {1'b1, exp_src, exp_d, exp_src ? TAG_W'(7 - i) : TAG_W'(i)}) begin
                errors++;
                $display("FAIL contention_rsp_%0d: got v=%b s=%b d=%h t=%0d expected v=1 s=%b d=%h",
                         i, rsp_valid, rsp_src, rsp_data, rsp_tag, exp_src, exp_d);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] held, exp_d1;
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 16'hC003; req0_shamt = 4'd2; req0_mode = 2'b01; req0_tag = 3'd5;
        tick();
        held = ref_shift(16'hC003, 4'd2, 2'b01);
        req0_data = 16'h0F0F; req0_tag = 3'd1;
        req1_valid = 1'b1; req1_data = 16'hABCD; req1_shamt = 4'd4; req1_mode = 2'b10; req1_tag = 3'd6;
        exp_d1 = ref_shift(16'hABCD, 4'd4, 2'b10);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready, rsp_valid, rsp_data, rsp_src, rsp_tag} !==
                {2'b00, 1'b1, held, 1'b0, 3'd5}) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: got r=%b%b v=%b d=%h s=%b t=%0d expected r=00 v=1 d=%h s=0 t=5",
                         i, req0_ready, req1_ready, rsp_valid, rsp_data, rsp_src, rsp_tag, held);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release_grant: got r0r1=%b%b expected 01", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_src, rsp_tag} !== {1'b1, exp_d1, 1'b1, 3'd6}) begin
            errors++;
            $display("FAIL backpressure_swap: got v=%b d=%h s=%b t=%0d expected v=1 d=%h s=1 t=6",
                     rsp_valid, rsp_data, rsp_src, rsp_tag, exp_d1);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mode_edge();
        logic rdy, v, osrc;
        logic [15:0] od;
        logic [TAG_W-1:0] otag;
        rsp_ready = 1'b1;
        send0(16'h0001, 4'd1, 2'b11, 3'd3, rdy, v, od, osrc, otag);
        checks++;
        if ({v, od} !== {1'b1, 16'h8000}) begin
            errors++;
            $display("FAIL mode11_ror: got v=%b d=%h expected v=1 d=8000", v, od);
        end
        for (int m = 0; m < 3; m++) begin
            send0(16'hA5C3, 4'd0, 2'(m), 3'd4, rdy, v, od, osrc, otag);
            checks++;
            if ({v, od} !== {1'b1, 16'hA5C3}) begin
                errors++;
                $display("FAIL shamt0_mode%0d: got v=%b d=%h expected v=1 d=a5c3", m, v, od);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h1111; req0_shamt = 4'd1; req0_mode = 2'b00; req0_tag = 3'd2;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        req1_valid = 1'b1; req1_data = 16'h2222; req1_shamt = 4'd0; req1_mode = 2'b00; req1_tag = 3'd7;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL midreset_discard: got v=%b d=%h expected v=0 d=0000", rsp_valid, rsp_data);
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 16'h3333; req0_tag = 3'd1; req0_shamt = 4'd0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_first_grant: got r0r1=%b%b expected 10", req0_ready, req1_ready);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_src, rsp_data, rsp_tag} !== {1'b1, 1'b0, 16'h3333, 3'd1}) begin
            errors++;
            $display("FAIL midreset_after: got v=%b s=%b d=%h t=%0d expected v=1 s=0 d=3333 t=1",
                     rsp_valid, rsp_src, rsp_data, rsp_tag);
        end
        idle_inputs();
        tick();
    endtask

    typedef struct packed {
        logic             src;
        logic [TAG_W-1:0] tag;
        logic [15:0]      data;
    } rsp_t;

    task automatic test_random();
        rsp_t buffer_q[$];
        rsp_t head;
        logic model_last;
        logic exp_g0, exp_g1, room;
        int per_src_sent [2];
        int per_src_seen [2];
        do_reset();
        model_last = 1'b1;
        per_src_sent = '{0, 0};
        per_src_seen = '{0, 0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_data = 16'($urandom); req0_shamt = 4'($urandom); req0_mode = 2'($urandom); req0_tag = TAG_W'($urandom);
            req1_data = 16'($urandom); req1_shamt = 4'($urandom); req1_mode = 2'($urandom); req1_tag = TAG_W'($urandom);
            rsp_ready = ($urandom_range(0, 99) < 65);
            #1;
            // Expected handshake from the model's occupancy and fairness memory.
            room = (buffer_q.size() == 0) || rsp_ready;
            if (req0_valid && req1_valid) begin
                exp_g0 = model_last; exp_g1 = !model_last;
            end else begin
                exp_g0 = req0_valid; exp_g1 = req1_valid;
            end
            exp_g0 = exp_g0 && room;
            exp_g1 = exp_g1 && room;
            checks++;
            if ({req0_ready, req1_ready} !== {exp_g0, exp_g1}) begin
                errors++;
                $display("FAIL random_ready_c%0d: got r0r1=%b%b expected %b%b",
                         cyc, req0_ready, req1_ready, exp_g0, exp_g1);
            end
            checks++;
            if (rsp_valid !== (buffer_q.size() != 0)) begin
                errors++;
                $display("FAIL random_valid_c%0d: got %b expected %b", cyc, rsp_valid, buffer_q.size() != 0);
            end
            if (buffer_q.size() != 0) begin
                head = buffer_q[0];
                checks++;
                if ({rsp_src, rsp_tag, rsp_data} !== head) begin
                    errors++;
                    $display("FAIL random_rsp_c%0d: got s=%b t=%0d d=%h expected s=%b t=%0d d=%h",
                             cyc, rsp_src, rsp_tag, rsp_data, head.src, head.tag, head.data);
                end
                if (rsp_ready) begin
                    void'(buffer_q.pop_front());
                    per_src_seen[head.src]++;
                end
            end
            if (exp_g0) begin
                buffer_q.push_back('{1'b0, req0_tag, ref_shift(req0_data, req0_shamt, req0_mode)});
                per_src_sent[0]++;
                model_last = 1'b0;
            end else if (exp_g1) begin
                buffer_q.push_back('{1'b1, req1_tag, ref_shift(req1_data, req1_shamt, req1_mode)});
                per_src_sent[1]++;
                model_last = 1'b1;
            end
            tick();
        end
        idle_inputs();
        rsp_ready = 1'b1;
        #1;
        if (buffer_q.size() != 0) begin
            head = buffer_q.pop_front();
            per_src_seen[head.src]++;
            checks++;
            if ({rsp_valid, rsp_src, rsp_tag, rsp_data} !== {1'b1, head}) begin
                errors++;
                $display("FAIL random_final: got v=%b s=%b t=%0d d=%h expected s=%b t=%0d d=%h",
                         rsp_valid, rsp_src, rsp_tag, rsp_data, head.src, head.tag, head.data);
            end
        end
        tick();
        checks++;
        if (per_src_sent[0] + per_src_sent[1] == 0 || per_src_seen[0] != per_src_sent[0] ||
            per_src_seen[1] != per_src_sent[1] || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_totals: got seen=%0d/%0d sent=%0d/%0d v=%b expected equal, v=0",
                     per_src_seen[0], per_src_seen[1], per_src_sent[0], per_src_sent[1], rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_mode_edge();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
